// File: rtl/exc_pkg.sv
// Package for the exception arbiter.
// Holds the exception-code constants shared with the thread csrs and the
// arbiter FSM state encoding.
package exc_pkg;

    localparam logic [5:0] EX_CLR   = 6'h00;
    localparam logic [5:0] ALU_EX   = 6'h01;
    localparam logic [5:0] IL_OP    = 6'h05;
    localparam logic [5:0] STACK_OV = 6'h0B;
    localparam logic [5:0] SEGFAULT = 6'h12;
    localparam logic [5:0] BRKPT    = 6'h3F;

    localparam int EXC_CNT_W = 16;

    typedef enum logic [1:0] {IDLE, REPORT, CLEAR, DRAIN} exc_state_t;

endpackage

// File: rtl/exc_arbiter_if.sv
// Host-side exception record port.
//   exc_valid  record valid (arbiter -> host)
//   exc_ready  host accepts record (host -> arbiter)
//   exc_idx    arbiter index of the reported thread
//   exc_thr    thread-id byte of the reported exception
//   exc_code   6-bit exception code
// master = arbiter side, slave = host side.
interface exc_arbiter_if #(
    parameter int IDX_W = 2
);
    logic             exc_valid;
    logic             exc_ready;
    logic [IDX_W-1:0] exc_idx;
    logic [7:0]       exc_thr;
    logic [5:0]       exc_code;

    modport master (
        output exc_valid, exc_idx, exc_thr, exc_code,
        input  exc_ready
    );

    modport slave (
        input  exc_valid, exc_idx, exc_thr, exc_code,
        output exc_ready
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin pick.
//   req_i      request vector
//   ptr_i      last-served index; search starts at ptr_i+1 (mod N)
//   gnt_idx_o  index of the winning request
//   gnt_vld_o  at least one request present
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_vld_o
);

    // Doubling the request vector and shifting by ptr turns the modular
    // search into a plain bit scan: dbl[k] == req[(ptr+k) mod N], k in 1..N.
    logic [2*N-1:0] dbl;

    assign dbl = {req_i, req_i} >> ptr_i;

    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        // Scan from the far end so the nearest request overwrites last.
        for (int k = N; k >= 1; k--) begin
            if (dbl[k]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = IDX_W'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/exc_arbiter.sv
// Central exception controller for NUM_THR per-thread csrs.
// Round-robin selects one stalled thread, reports its record to the host
// over a valid/ready port, pulses that thread's clr_ex after the handshake
// and waits (bounded by CLR_TMO) for its stall to drop before re-arbitrating.
//   clk, rst         clock, synchronous active-high reset
//   thr_stall_i      per-thread csr_stall
//   thr_ex_cause_i   per-thread ex_cause, thread i at [6i+:6]
//   thr_cause_id_i   per-thread id byte, thread i at [8i+:8]
//   thr_clr_ex_o     one-hot clr_ex pulse back to the thread csrs
//   exc_count_o      accepted exceptions, saturating
//   clr_err_o        sticky: a thread failed to clear within CLR_TMO
//   host             exception record port (valid/ready, idx, thr, code)
module exc_arbiter
    import exc_pkg::*;
#(
    parameter int NUM_THR = 4,
    parameter int IDX_W   = $clog2(NUM_THR),
    parameter int CLR_TMO = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_THR-1:0]     thr_stall_i,
    input  logic [6*NUM_THR-1:0]   thr_ex_cause_i,
    input  logic [8*NUM_THR-1:0]   thr_cause_id_i,
    output logic [NUM_THR-1:0]     thr_clr_ex_o,
    output logic [EXC_CNT_W-1:0]   exc_count_o,
    output logic                   clr_err_o,
    exc_arbiter_if.master          host
);

    localparam int TMO_W = $clog2(CLR_TMO + 1);

    exc_state_t           state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [5:0]           cause_q, cause_d;
    logic [7:0]           id_q, id_d;
    logic [EXC_CNT_W-1:0] exc_count_q, exc_count_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                 clr_err_q, clr_err_d;

    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_vld;
    logic [5:0]           cause_arr [NUM_THR];
    logic [7:0]           id_arr    [NUM_THR];

    for (genvar i = 0; i < NUM_THR; i++) begin : g_unpack
        assign cause_arr[i] = thr_ex_cause_i[6*i +: 6];
        assign id_arr[i]    = thr_cause_id_i[8*i +: 8];
    end

    rr_arbiter #(.N(NUM_THR), .IDX_W(IDX_W)) u_rr (
        .req_i     (thr_stall_i),
        .ptr_i     (rr_ptr_q),
        .gnt_idx_o (arb_idx),
        .gnt_vld_o (arb_vld)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        cause_d     = cause_q;
        id_d        = id_q;
        exc_count_d = exc_count_q;
        tmo_cnt_d   = tmo_cnt_q;
        clr_err_d   = clr_err_q;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    grant_d = arb_idx;
                    cause_d = cause_arr[arb_idx];
                    id_d    = id_arr[arb_idx];
                    state_d = REPORT;
                end
            end
            REPORT: begin
                // Record registers are frozen here; input changes are ignored.
                if (host.exc_ready) begin
                    state_d = CLEAR;
                    if (exc_count_q != '1) exc_count_d = exc_count_q + 1'b1;
                end
            end
            CLEAR: begin
                tmo_cnt_d = '0;
                state_d   = DRAIN;
            end
            DRAIN: begin
                if (!thr_stall_i[grant_q]) begin
                    rr_ptr_d = grant_q;
                    state_d  = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    // Timeout lands exactly CLR_TMO cycles after DRAIN entry;
                    // the stuck thread drops to lowest priority via rr_ptr.
                    if (tmo_cnt_d == TMO_W'(CLR_TMO)) begin
                        clr_err_d = 1'b1;
                        rr_ptr_d  = grant_q;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDX_W'(NUM_THR - 1);
            grant_q     <= '0;
            cause_q     <= '0;
            id_q        <= '0;
            exc_count_q <= '0;
            tmo_cnt_q   <= '0;
            clr_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            cause_q     <= cause_d;
            id_q        <= id_d;
            exc_count_q <= exc_count_d;
            tmo_cnt_q   <= tmo_cnt_d;
            clr_err_q   <= clr_err_d;
        end
    end

    // Gating with rst keeps a reset that lands on a REPORT/CLEAR cycle from
    // ever presenting a record or a clr_ex at the sampling edge.
    assign host.exc_valid = (state_q == REPORT) && !rst;
    assign host.exc_idx   = grant_q;
    assign host.exc_thr   = id_q;
    assign host.exc_code  = cause_q;
    assign thr_clr_ex_o   = (state_q == CLEAR && !rst)
                          ? ({{(NUM_THR-1){1'b0}}, 1'b1} << grant_q) : '0;
    assign exc_count_o    = exc_count_q;
    assign clr_err_o      = clr_err_q;

endmodule
